// File: rtl/harvard_mem_arbiter.sv
// Single-port memory arbiter sequencing mips_cpu_harvard: fetch, optional data access, commit.
// Define HARVARD_ARB_PERF_CNT_EN to add the perf_commits / perf_wait_cycles counters.
module harvard_mem_arbiter #(
    parameter int          WAIT_TIMEOUT = 255,
    parameter logic [31:0] RESET_VECTOR = 32'hBFC00000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_active,
    output logic        cpu_clk_enable,
    input  logic [31:0] instr_address,
    output logic [31:0] instr_readdata,
    input  logic [31:0] data_address,
    input  logic        data_read,
    input  logic        data_write,
    input  logic [31:0] data_writedata,
    output logic [31:0] data_readdata,
    output logic [31:0] mem_address,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_writedata,
    input  logic [31:0] mem_readdata,
    input  logic        mem_waitrequest,
    output logic        error
`ifdef HARVARD_ARB_PERF_CNT_EN
    ,
    output logic [31:0] perf_commits,
    output logic [31:0] perf_wait_cycles
`endif
);

    typedef enum logic [2:0] {IDLE, FETCH, EXEC, COMMIT, HALT, ERROR} state_t;

    localparam int          CW     = (WAIT_TIMEOUT > 0) ? $clog2(WAIT_TIMEOUT + 1) : 1;
    localparam logic [CW:0] TO_LIM = (CW + 1)'(WAIT_TIMEOUT);

    state_t        state;
    logic [CW-1:0] wait_cnt;
    logic [CW:0]   wait_nxt;
    logic          req;
    logic          accept;
    logic          stall;
    logic          timeout;

    // Request lines decode straight from state: the CPU address is live and only
    // frozen by the withheld clock enable, so registering it would lag a cycle.
    always_comb begin
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        mem_address   = RESET_VECTOR;
        mem_writedata = '0;
        case (state)
            FETCH: begin
                mem_read    = 1'b1;
                mem_address = instr_address;
            end
            EXEC: begin
                mem_read  = data_read & ~data_write;
                mem_write = data_write & ~data_read;
                if (data_read ^ data_write)
                    mem_address = data_address;
                if (data_write & ~data_read)
                    mem_writedata = data_writedata;
            end
            default: ;
        endcase
    end

    assign req      = mem_read | mem_write;
    assign accept   = req & ~mem_waitrequest;
    assign stall    = req & mem_waitrequest;
    assign wait_nxt = {1'b0, wait_cnt} + 1'b1;
    assign timeout  = (WAIT_TIMEOUT != 0) && stall && (wait_nxt == TO_LIM);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            cpu_clk_enable <= 1'b0;
            error          <= 1'b0;
            instr_readdata <= '0;
            data_readdata  <= '0;
            wait_cnt       <= '0;
        end else begin
            cpu_clk_enable <= 1'b0;
            if (stall) begin
                if (wait_cnt != '1)
                    wait_cnt <= wait_nxt[CW-1:0];
            end else begin
                wait_cnt <= '0;
            end

            case (state)
                IDLE:
                    if (cpu_active)
                        state <= FETCH;
                FETCH:
                    if (timeout) begin
                        state <= ERROR;
                        error <= 1'b1;
                    end else if (accept) begin
                        instr_readdata <= mem_readdata;
                        state          <= EXEC;
                    end
                EXEC:
                    if ((data_read && data_write) || timeout) begin
                        state <= ERROR;
                        error <= 1'b1;
                    end else if (!req || accept) begin
                        if (data_read)
                            data_readdata <= mem_readdata;
                        state          <= COMMIT;
                        cpu_clk_enable <= 1'b1;
                    end
                COMMIT:
                    state <= cpu_active ? FETCH : HALT;
                HALT:  state <= HALT;
                ERROR: error <= 1'b1;
                default: begin
                    state <= ERROR;
                    error <= 1'b1;
                end
            endcase
        end
    end

`ifdef HARVARD_ARB_PERF_CNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_commits     <= '0;
            perf_wait_cycles <= '0;
        end else begin
            if (state == COMMIT && perf_commits != 32'hFFFFFFFF)
                perf_commits <= perf_commits + 32'd1;
            if (stall && perf_wait_cycles != 32'hFFFFFFFF)
                perf_wait_cycles <= perf_wait_cycles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_harvard_mem_arbiter.sv
// Directed bench for harvard_mem_arbiter with a wait-stated unified memory model.
module tb_harvard_mem_arbiter;

    localparam logic [31:0] RV = 32'hBFC00000;

    logic        clk, reset, cpu_active, cpu_clk_enable;
    logic [31:0] instr_address, instr_readdata, data_address, data_writedata, data_readdata;
    logic        data_read, data_write;
    logic [31:0] mem_address, mem_writedata, mem_readdata;
    logic        mem_read, mem_write, mem_waitrequest, error;
`ifdef HARVARD_ARB_PERF_CNT_EN
    logic [31:0] perf_commits, perf_wait_cycles;
`endif

    logic [31:0] mem [0:255];
    int          wi, wd, wcnt, wr_cnt;
    logic        stuck;
    int          n_chk = 0;
    int          n_fail = 0;

    harvard_mem_arbiter #(.WAIT_TIMEOUT(4), .RESET_VECTOR(RV)) dut (
        .clk(clk), .reset(reset), .cpu_active(cpu_active), .cpu_clk_enable(cpu_clk_enable),
        .instr_address(instr_address), .instr_readdata(instr_readdata),
        .data_address(data_address), .data_read(data_read), .data_write(data_write),
        .data_writedata(data_writedata), .data_readdata(data_readdata),
        .mem_address(mem_address), .mem_read(mem_read), .mem_write(mem_write),
        .mem_writedata(mem_writedata), .mem_readdata(mem_readdata),
        .mem_waitrequest(mem_waitrequest), .error(error)
`ifdef HARVARD_ARB_PERF_CNT_EN
        , .perf_commits(perf_commits), .perf_wait_cycles(perf_wait_cycles)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory: per-access wait count chosen by whether this is the instruction fetch.
    int wn;
    assign wn              = (mem_read && mem_address == instr_address) ? wi : wd;
    assign mem_waitrequest = stuck | ((mem_read | mem_write) && (wcnt < wn));
    assign mem_readdata    = mem[mem_address[9:2]];

    always @(posedge clk) begin
        wcnt <= ((mem_read | mem_write) && mem_waitrequest) ? wcnt + 1 : 0;
        if (mem_write && !mem_waitrequest) begin
            mem[mem_address[9:2]] <= mem_writedata;
            wr_cnt <= wr_cnt + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        reset = 1'b1;
        cpu_active = 1'b0;
        data_read = 1'b0;
        data_write = 1'b0;
        step;
        step;
        reset = 1'b0;
    endtask

    int pulses, reads_after, wr_cycles, w0;

    initial begin
        reset = 1'b1; cpu_active = 1'b0; stuck = 1'b0;
        instr_address = 32'h40; data_address = 32'h0; data_writedata = 32'h0;
        data_read = 1'b0; data_write = 1'b0;
        wi = 0; wd = 0; wcnt = 0; wr_cnt = 0;
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        mem[0]  = 32'hDEADBEEF;
        mem[16] = 32'h01234567;
        mem[17] = 32'h8C000000;
        mem[18] = 32'hAC000004;

        step;
        chk("rst_rd", {31'b0, mem_read}, 32'd0);
        chk("rst_wr", {31'b0, mem_write}, 32'd0);
        chk("rst_addr", mem_address, RV);
        chk("rst_err", {31'b0, error}, 32'd0);
        chk("rst_cke", {31'b0, cpu_clk_enable}, 32'd0);
        chk("rst_ir", instr_readdata, 32'd0);
        chk("rst_dr", data_readdata, 32'd0);
        step;
        reset = 1'b0;

        // Zero-wait ALU instruction
        cpu_active = 1'b1;
        step;
        chk("alu_c1_rd", {31'b0, mem_read}, 32'd1);
        chk("alu_c1_addr", mem_address, 32'h40);
        chk("alu_c1_cke", {31'b0, cpu_clk_enable}, 32'd0);
        step;
        chk("alu_c2_ir", instr_readdata, 32'h01234567);
        chk("alu_c2_noreq", {30'b0, mem_read, mem_write}, 32'd0);
        chk("alu_c2_cke", {31'b0, cpu_clk_enable}, 32'd0);
        step;
        chk("alu_c3_cke", {31'b0, cpu_clk_enable}, 32'd1);
        chk("alu_c3_noreq", {30'b0, mem_read, mem_write}, 32'd0);
        instr_address = 32'h44; wd = 2;
        step;
        chk("alu_c4_rd", {31'b0, mem_read}, 32'd1);
        chk("alu_c4_addr", mem_address, 32'h44);
        chk("alu_c4_cke", {31'b0, cpu_clk_enable}, 32'd0);

        // Load with 2 wait cycles on the data access
        step;
        data_read = 1'b1; data_address = 32'h00001000;
        #1;
        chk("ld_c2_rd", {31'b0, mem_read}, 32'd1);
        chk("ld_c2_addr", mem_address, 32'h00001000);
        chk("ld_c2_wait", {31'b0, mem_waitrequest}, 32'd1);
        step;
        chk("ld_c3_addr", mem_address, 32'h00001000);
        chk("ld_c3_cke", {31'b0, cpu_clk_enable}, 32'd0);
        step;
        chk("ld_c4_addr", mem_address, 32'h00001000);
        chk("ld_c4_wait", {31'b0, mem_waitrequest}, 32'd0);
        chk("ld_c4_dr_old", data_readdata, 32'd0);
        step;
        chk("ld_c5_cke", {31'b0, cpu_clk_enable}, 32'd1);
        chk("ld_c5_dr", data_readdata, 32'hDEADBEEF);
        chk("ld_c5_ir", instr_readdata, 32'h8C000000);

        // Store with 3 wait cycles; cpu_active drops before commit
        instr_address = 32'h48; wd = 3;
        step;
        data_read = 1'b0;
        chk("st_fetch_addr", mem_address, 32'h48);
        step;
        data_write = 1'b1; data_address = 32'h00001004; data_writedata = 32'h12345678;
        cpu_active = 1'b0; w0 = wr_cnt;
        #1;
        chk("st_c2_wr", {31'b0, mem_write}, 32'd1);
        chk("st_c2_rd", {31'b0, mem_read}, 32'd0);
        chk("st_c2_addr", mem_address, 32'h00001004);
        chk("st_c2_wdata", mem_writedata, 32'h12345678);
        pulses = 0; reads_after = 0; wr_cycles = 0;
        for (int i = 0; i < 25; i++) begin
            step;
            if (pulses > 0 && mem_read) reads_after++;
            if (cpu_clk_enable) pulses++;
            if (mem_write) wr_cycles++;
        end
        chk("st_pulses", pulses, 32'd1);
        chk("st_wr_cycles", wr_cycles, 32'd3);
        chk("st_accepted", wr_cnt - w0, 32'd1);
        chk("st_mem", mem[1], 32'h12345678);
        chk("halt_no_rd", reads_after, 32'd0);
        chk("halt_err", {31'b0, error}, 32'd0);
        chk("halt_ir", instr_readdata, 32'hAC000004);
        chk("halt_dr", data_readdata, 32'hDEADBEEF);

        // Simultaneous load and store is a protocol error
        wd = 0; instr_address = 32'h40;
        do_reset;
        cpu_active = 1'b1;
        step;
        step;
        data_read = 1'b1; data_write = 1'b1; data_address = 32'h00001000;
        #1;
        chk("both_noreq", {30'b0, mem_read, mem_write}, 32'd0);
        step;
        chk("both_err", {31'b0, error}, 32'd1);
        chk("both_cke", {31'b0, cpu_clk_enable}, 32'd0);

        // Watchdog with waitrequest stuck high
        do_reset;
        stuck = 1'b1; cpu_active = 1'b1;
        step;
        chk("wd_c1_err", {31'b0, error}, 32'd0);
        step; step; step;
        chk("wd_c4_err", {31'b0, error}, 32'd0);
        chk("wd_c4_rd", {31'b0, mem_read}, 32'd1);
        step;
        chk("wd_c5_err", {31'b0, error}, 32'd1);
        chk("wd_c5_noreq", {30'b0, mem_read, mem_write}, 32'd0);
        step;
        chk("wd_sticky", {31'b0, error}, 32'd1);

        // Reset in mid-fetch drops the request immediately
        do_reset;
        cpu_active = 1'b1;
        step;
        chk("mid_rd_before", {31'b0, mem_read}, 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("mid_rd", {31'b0, mem_read}, 32'd0);
        chk("mid_addr", mem_address, RV);
        chk("mid_err", {31'b0, error}, 32'd0);
        stuck = 1'b0;

        // Ten zero-wait instructions
        do_reset;
        wi = 0; wd = 0; cpu_active = 1'b1;
        pulses = 0;
        for (int i = 0; i < 31; i++) begin
            step;
            if (cpu_clk_enable) pulses++;
        end
        chk("run10_pulses", pulses, 32'd10);
        chk("run10_rd", {31'b0, mem_read}, 32'd1);
`ifdef HARVARD_ARB_PERF_CNT_EN
        chk("perf_commits", perf_commits, 32'd10);
        chk("perf_wait", perf_wait_cycles, 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/harvard_mem_arbiter.md
Name: harvard_mem_arbiter

Overview:
- Shares one single-ported, wait-stated memory between the instruction and data ports of mips_cpu_harvard.
- Sequences the CPU through its clk_enable input: instruction fetch first, then an optional data access, then one enabled CPU clock edge.
- Sits between cpuInst and a unified memory model in the system top level and bench.

Parameters:
- WAIT_TIMEOUT, 255: max consecutive mem_waitrequest cycles per access before the block enters ERROR; 0 disables the watchdog.
- RESET_VECTOR, 32'hBFC00000: reported on mem_address while idle; not driven as a request.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- cpu_active  input  1  CPU active flag
- cpu_clk_enable  output  1  one-cycle CPU advance strobe
- instr_address  input  32  CPU fetch address
- instr_readdata  output  32  registered fetched instruction
- data_address  input  32  CPU data address
- data_read  input  1  CPU load request
- data_write  input  1  CPU store request
- data_writedata  input  32  CPU store data
- data_readdata  output  32  registered load data
- mem_address  output  32  unified memory address
- mem_read  output  1  memory read request
- mem_write  output  1  memory write request
- mem_writedata  output  32  memory write data
- mem_readdata  input  32  memory read data, valid when the request is accepted
- mem_waitrequest  input  1  memory stall; a request is accepted on the edge where it is 0
- error  output  1  sticky protocol/timeout error

Behaviour:
- Reset (async): state IDLE; cpu_clk_enable, mem_read, mem_write and error are 0; instr_readdata and data_readdata are 0; mem_address is RESET_VECTOR. A reset in mid-access drops requests immediately. There is no completion and no partial commit.
- States: IDLE, FETCH, EXEC, COMMIT, HALT, ERROR.
- IDLE: when cpu_active=1, go to FETCH.
- FETCH:
  - Drive mem_read=1 and mem_address=instr_address.
  - Address and read are held stable while mem_waitrequest=1.
  - On acceptance, instr_readdata<=mem_readdata and go to EXEC.
- EXEC: the CPU decodes from the held instr_readdata.
  - data_read=1: mem_read=1, mem_address=data_address. On acceptance, data_readdata<=mem_readdata and go to COMMIT.
  - data_write=1: mem_write=1, mem_address=data_address, mem_writedata=data_writedata. On acceptance go to COMMIT. Exactly one write is issued per instruction.
  - Neither: no request; go to COMMIT next cycle.
  - Both: set error and go to ERROR.
- COMMIT:
  - cpu_clk_enable=1 for exactly this cycle, so the CPU advances once on this edge. No memory request.
  - Next state: FETCH if cpu_active=1, else HALT.
- HALT: all requests are 0; cpu_clk_enable=0; stays until reset.
- ERROR: all requests are 0; error=1; cpu_clk_enable=0; stays until reset.
- Watchdog:
  - A counter clears at each new request and increments per cycle with mem_waitrequest=1.
  - When the count reaches WAIT_TIMEOUT (and WAIT_TIMEOUT != 0), set error and go to ERROR.
  - The counter is wide enough for WAIT_TIMEOUT; it does not wrap.
- Latency: with zero wait states, 3 cycles per instruction, loads and stores included. Each wait cycle adds 1.
- instr_readdata and data_readdata change only on an accepted read. They stay stable through COMMIT.
- mem_read and mem_write are never both 1.

Optional Feature:
- HARVARD_ARB_PERF_CNT_EN defined: adds two 32-bit outputs, perf_commits and perf_wait_cycles.
  - perf_commits increments per COMMIT cycle.
  - perf_wait_cycles increments per cycle with a request pending and mem_waitrequest=1.
  - Both are reset to 0 and saturate at 32'hFFFFFFFF.
- Undefined: neither port nor counter exists. Behaviour is otherwise identical.

Test Plan:
- Zero-wait ALU instruction, cpu_active=1 -> mem_read with instr_address in cycle 1, cpu_clk_enable pulse in cycle 3, next fetch in cycle 4; instr_readdata equals memory word.
- Load at data_address=32'h00001000, memory 32'hDEADBEEF, 2 wait cycles on the data access -> data_readdata=32'hDEADBEEF, address held for 3 cycles, commit at cycle 5.
- Store data_writedata=32'h12345678 with 3 wait cycles -> exactly one accepted mem_write, memory updated once, a single cpu_clk_enable pulse.
- cpu_active falls before COMMIT -> one final pulse, then HALT; no further mem_read for 20 cycles.
- WAIT_TIMEOUT=4, mem_waitrequest stuck at 1 -> error=1 after 4 wait cycles, requests 0; reset asserted mid-FETCH -> mem_read=0 the same cycle, IDLE, error=0.
- With HARVARD_ARB_PERF_CNT_EN: 10 zero-wait instructions -> perf_commits=10, perf_wait_cycles=0.
